exe_stage: RTL and testbench

//   Execute stage, directly downstream of the ID/EXE pipeline register. Consumes its _exe control/data

---
 rtl/exe_stage_pkg.sv | 37 +++
 rtl/exe_stage_mul.sv | 88 ++++++++
 rtl/exe_stage.sv | 141 ++++++++++++++
 tb/tb_exe_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared constants and types for the execute stage.
//   DATA_WIDTH  - default datapath width
//   alu_op_e    - ALU operation encodings carried on alucontrol_exe
//   fwd_sel_e   - operand forward-select encodings
//   mul_state_e - iterative multiplier FSM states
package exe_stage_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_NOR = 4'b1100,
    ALU_XOR = 4'b1101,
    ALU_MUL = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_e;

endpackage

// File: rtl/exe_stage_mul.sv
// iter_mul: shift-add iterative multiplier, one partial-product step per cycle.
//   clk, rst  - clock, synchronous active-high reset (aborts any multiply)
//   start     - accepted only in IDLE; latches a and b
//   a, b      - operands
//   busy      - high while stepping (WIDTH cycles)
//   done      - high for the single cycle in which product is final
//   product   - low WIDTH bits of a*b, valid while done is high
module iter_mul
  import exe_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    count_d = count_q;
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          count_d = CW'(WIDTH);
          state_d = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (b_q[0]) begin
          acc_d = acc_q + a_q;
        end
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        count_d = count_q - CW'(1);
        // The step taken at count==1 is the last one.
        if (count_q == CW'(1)) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        state_d = MUL_IDLE;
      end
      default: begin
        state_d = MUL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign busy    = (state_q == MUL_BUSY);
  assign done    = (state_q == MUL_DONE);
  assign product = acc_q;

endmodule

// File: rtl/exe_stage.sv
// exe_stage: pipeline execute stage.
//   Inputs : ID/EXE control (*_exe), register specifiers, operands, immediate,
//            shift amount, forward selects, writeback result for forwarding.
//   Outputs: stall_exe (hold front end during a multiply) and the registered
//            EXE/MEM boundary (regwrite/memtoreg/memwrite_mem, aluout_mem,
//            writedata_mem, writereg_mem).
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regwrite_exe,
  input  logic             memtoreg_exe,
  input  logic             memwrite_exe,
  input  logic             alusrc_exe,
  input  logic             regdst_exe,
  input  logic [3:0]       alucontrol_exe,
  input  logic [4:0]       Rs_exe,
  input  logic [4:0]       Rt_exe,
  input  logic [4:0]       Rd_exe,
  input  logic [WIDTH-1:0] data1_exe,
  input  logic [WIDTH-1:0] data2_exe,
  input  logic [WIDTH-1:0] signext_exe,
  input  logic [4:0]       shamt_exe,
  input  logic [1:0]       forwardA_exe,
  input  logic [1:0]       forwardB_exe,
  input  logic [WIDTH-1:0] result_wb,
  output logic             stall_exe,
  output logic             regwrite_mem,
  output logic             memtoreg_mem,
  output logic             memwrite_mem,
  output logic [WIDTH-1:0] aluout_mem,
  output logic [WIDTH-1:0] writedata_mem,
  output logic [4:0]       writereg_mem
);

  logic [WIDTH-1:0] fwd_a, fwd_b, src_a, src_b, alu_result, mul_product;
  logic             is_mul, mul_idle, mul_busy, mul_done, mul_start, hold;

  logic             regwrite_q, regwrite_d;
  logic             memtoreg_q, memtoreg_d;
  logic             memwrite_q, memwrite_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic [WIDTH-1:0] writedata_q, writedata_d;
  logic [4:0]       writereg_q, writereg_d;

  // Rs is consumed by the hazard unit upstream, not here.
  logic unused_rs;
  assign unused_rs = ^Rs_exe;

  always_comb begin
    case (forwardA_exe)
      FWD_WB:  fwd_a = result_wb;
      FWD_MEM: fwd_a = aluout_q;
      default: fwd_a = data1_exe;
    endcase
    case (forwardB_exe)
      FWD_WB:  fwd_b = result_wb;
      FWD_MEM: fwd_b = aluout_q;
      default: fwd_b = data2_exe;
    endcase
    src_a = fwd_a;
    src_b = alusrc_exe ? signext_exe : fwd_b;
  end

  always_comb begin
    alu_result = '0;
    case (alucontrol_exe)
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_SLT: alu_result[0] = ($signed(src_a) < $signed(src_b));
      ALU_SLL: alu_result = src_b << shamt_exe;
      ALU_SRL: alu_result = src_b >> shamt_exe;
      ALU_SRA: alu_result = $unsigned($signed(src_b) >>> shamt_exe);
      ALU_NOR: alu_result = ~(src_a | src_b);
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_MUL: alu_result = mul_product;
      default: alu_result = '0;
    endcase
  end

  // Stall covers the IDLE start cycle plus every BUSY cycle; the DONE cycle
  // releases the front end while EXE/MEM captures the product.
  assign is_mul    = (alucontrol_exe == ALU_MUL);
  assign mul_idle  = !mul_busy && !mul_done;
  assign mul_start = is_mul && mul_idle;
  assign hold      = mul_start || mul_busy;
  assign stall_exe = !rst && hold;

  iter_mul #(
    .WIDTH(WIDTH)
  ) u_iter_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    regwrite_d  = regwrite_exe && !hold;
    memtoreg_d  = memtoreg_exe && !hold;
    memwrite_d  = memwrite_exe && !hold;
    aluout_d    = alu_result;
    writedata_d = fwd_b;
    writereg_d  = regdst_exe ? Rd_exe : Rt_exe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      aluout_q    <= '0;
      writedata_q <= '0;
      writereg_q  <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      memwrite_q  <= memwrite_d;
      aluout_q    <= aluout_d;
      writedata_q <= writedata_d;
      writereg_q  <= writereg_d;
    end
  end

  assign regwrite_mem  = regwrite_q;
  assign memtoreg_mem  = memtoreg_q;
  assign memwrite_mem  = memwrite_q;
  assign aluout_mem    = aluout_q;
  assign writedata_mem = writedata_q;
  assign writereg_mem  = writereg_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized and directed bench for exe_stage against a
// behavioural model of the ALU, forwarding and multiply timing.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite_exe, memtoreg_exe, memwrite_exe, alusrc_exe, regdst_exe;
  logic [3:0]  alucontrol_exe;
  logic [4:0]  Rs_exe, Rt_exe, Rd_exe, shamt_exe;
  logic [31:0] data1_exe, data2_exe, signext_exe, result_wb;
  logic [1:0]  forwardA_exe, forwardB_exe;
  logic        stall_exe, regwrite_mem, memtoreg_mem, memwrite_mem;
  logic [31:0] aluout_mem, writedata_mem;
  logic [4:0]  writereg_mem;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] model_mem = '0;  // expected aluout_mem, used as the MEM forward source

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .regwrite_exe(regwrite_exe), .memtoreg_exe(memtoreg_exe), .memwrite_exe(memwrite_exe),
    .alusrc_exe(alusrc_exe), .regdst_exe(regdst_exe), .alucontrol_exe(alucontrol_exe),
    .Rs_exe(Rs_exe), .Rt_exe(Rt_exe), .Rd_exe(Rd_exe),
    .data1_exe(data1_exe), .data2_exe(data2_exe), .signext_exe(signext_exe),
    .shamt_exe(shamt_exe), .forwardA_exe(forwardA_exe), .forwardB_exe(forwardB_exe),
    .result_wb(result_wb), .stall_exe(stall_exe),
    .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem), .memwrite_mem(memwrite_mem),
    .aluout_mem(aluout_mem), .writedata_mem(writedata_mem), .writereg_mem(writereg_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'b1000: r = b << sh;
      4'b1001: r = b >> sh;
      4'b1010: begin
        r = b >> sh;
        if (b[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      4'b1100: r = ~(a | b);
      4'b1101: r = a ^ b;
      4'b1110: r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] regv);
    if (sel == 2'b01) return result_wb;
    if (sel == 2'b10) return model_mem;
    return regv;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2);
    alucontrol_exe = op;
    data1_exe      = d1;
    data2_exe      = d2;
    regwrite_exe   = 1'b1;
    memtoreg_exe   = 1'b0;
    memwrite_exe   = 1'b0;
    alusrc_exe     = 1'b0;
    regdst_exe     = 1'b1;
    forwardA_exe   = 2'b00;
    forwardB_exe   = 2'b00;
    Rs_exe         = 5'($urandom);
    Rt_exe         = 5'($urandom);
    Rd_exe         = 5'($urandom);
    shamt_exe      = 5'($urandom);
    signext_exe    = $urandom;
    result_wb      = $urandom;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_op(4'($urandom), $urandom, $urandom);
    regwrite_exe = 1'b1; memwrite_exe = 1'b1; memtoreg_exe = 1'b1;
    tick;
    alucontrol_exe = 4'b1110;  // MUL while in reset must not stall
    data1_exe = $urandom;
    #1;
    vectors++;
    if (stall_exe !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_exe); end
    tick;
    vectors++;
    if ({regwrite_mem, memtoreg_mem, memwrite_mem} !== 3'b000 || aluout_mem !== 32'd0 ||
        writedata_mem !== 32'd0 || writereg_mem !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ctrl=%b alu=%h wd=%h wr=%0d want all 0",
               {regwrite_mem, memtoreg_mem, memwrite_mem}, aluout_mem, writedata_mem, writereg_mem);
    end
    model_mem = '0;
    rst = 1'b0;
    drive_op(4'b0010, 32'd5, 32'd7);
    #1;
    vectors++;
    if (stall_exe !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %b want 0", stall_exe); end
    tick;
    vectors++;
    if (aluout_mem !== 32'd12 || regwrite_mem !== 1'b1 || writereg_mem !== Rd_exe) begin
      errors++;
      $display("FAIL first_op: got alu=%h rw=%b wr=%0d want 0000000c 1 %0d",
               aluout_mem, regwrite_mem, writereg_mem, Rd_exe);
    end
    model_mem = 32'd12;
  endtask

  task automatic test_alu_directed;
    logic [3:0]  ops [4] = '{4'b0010, 4'b0110, 4'b0111, 4'b1010};
    logic [31:0] as  [4] = '{32'd5, 32'd3, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] bs  [4] = '{32'd7, 32'd5, 32'd1, 32'h8000_0000};
    logic [31:0] exp [4] = '{32'd12, 32'hFFFF_FFFE, 32'd1, 32'hF800_0000};
    for (int i = 0; i < 4; i++) begin
      drive_op(ops[i], as[i], bs[i]);
      shamt_exe  = 5'd4;
      regdst_exe = i[0];
      tick;
      vectors++;
      if (aluout_mem !== exp[i] || writereg_mem !== (i[0] ? Rd_exe : Rt_exe)) begin
        errors++;
        $display("FAIL alu_directed_%0d: got alu=%h wr=%0d want %h %0d",
                 i, aluout_mem, writereg_mem, exp[i], i[0] ? Rd_exe : Rt_exe);
      end
      model_mem = exp[i];
    end
  endtask

  task automatic test_alu_random;
    logic [31:0] fa, fb, exp_alu;
    for (int i = 0; i < 60; i++) begin
      drive_op(4'($urandom), $urandom, $urandom);
      if (alucontrol_exe == 4'b1110) alucontrol_exe = 4'b0010;
      if (i % 4 == 0) data2_exe = 32'($urandom_range(0, 9));
      regwrite_exe = 1'($urandom); memtoreg_exe = 1'($urandom); memwrite_exe = 1'($urandom);
      alusrc_exe   = 1'($urandom); regdst_exe   = 1'($urandom);
      forwardA_exe = 2'($urandom); forwardB_exe = 2'($urandom);
      fa = ref_fwd(forwardA_exe, data1_exe);
      fb = ref_fwd(forwardB_exe, data2_exe);
      exp_alu = ref_alu(alucontrol_exe, fa, alusrc_exe ? signext_exe : fb, shamt_exe);
      #1;
      vectors++;
      if (stall_exe !== 1'b0) begin errors++; $display("FAIL rand_stall_%0d: got %b want 0", i, stall_exe); end
      tick;
      vectors++;
      if (aluout_mem !== exp_alu || writedata_mem !== fb ||
          writereg_mem !== (regdst_exe ? Rd_exe : Rt_exe) ||
          {regwrite_mem, memtoreg_mem, memwrite_mem} !== {regwrite_exe, memtoreg_exe, memwrite_exe}) begin
        errors++;
        $display("FAIL rand_alu_%0d op=%b: got alu=%h wd=%h wr=%0d ctrl=%b want %h %h %0d %b",
                 i, alucontrol_exe, aluout_mem, writedata_mem, writereg_mem,
                 {regwrite_mem, memtoreg_mem, memwrite_mem}, exp_alu, fb,
                 regdst_exe ? Rd_exe : Rt_exe, {regwrite_exe, memtoreg_exe, memwrite_exe});
      end
      model_mem = exp_alu;
    end
  endtask

  task automatic test_forwarding;
    for (int k = 0; k < 2; k++) begin
      drive_op(4'b0010, 32'h8, 32'h8);
      tick;
      vectors++;
      if (aluout_mem !== 32'h10) begin errors++; $display("FAIL fwd_setup_%0d: got %h want 00000010", k, aluout_mem); end
      model_mem = 32'h10;
      drive_op(4'b0010, $urandom, $urandom);
      forwardA_exe = 2'b10;
      forwardB_exe = 2'b01;
      result_wb    = 32'h3;
      alusrc_exe   = (k == 1);
      signext_exe  = 32'h4;
      tick;
      vectors++;
      if (aluout_mem !== (k == 1 ? 32'h14 : 32'h13) || writedata_mem !== 32'h3) begin
        errors++;
        $display("FAIL fwd_add_%0d: got alu=%h wd=%h want %h 00000003",
                 k, aluout_mem, writedata_mem, k == 1 ? 32'h14 : 32'h13);
      end
      model_mem = (k == 1) ? 32'h14 : 32'h13;
    end
  endtask

  // Runs one MUL to completion, scrambling the operand sources while stalled.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, output int cycles);
    bit finished = 0;
    logic [4:0] rd;
    drive_op(4'b1110, a, b);
    rd = Rd_exe;
    cycles = 0;
    for (int i = 0; i < 100 && !finished; i++) begin
      #1;
      if (stall_exe === 1'b1) begin
        cycles++;
        tick;
        vectors++;
        if (regwrite_mem !== 1'b0) begin
          errors++;
          $display("FAIL mul_bubble_%0d: got regwrite_mem=%b want 0", cycles, regwrite_mem);
        end
        data1_exe = $urandom; data2_exe = $urandom; result_wb = $urandom;
      end else begin
        finished = 1;
      end
    end
    if (!finished) begin
      vectors++; errors++;
      $display("FAIL mul_timeout: stall still high after %0d cycles, want release", cycles);
    end
    tick;
    vectors++;
    if (aluout_mem !== a * b || regwrite_mem !== 1'b1 || writereg_mem !== rd) begin
      errors++;
      $display("FAIL mul_result %h*%h: got alu=%h rw=%b wr=%0d want %h 1 %0d",
               a, b, aluout_mem, regwrite_mem, writereg_mem, a * b, rd);
    end
    model_mem = a * b;
  endtask

  task automatic test_mul;
    logic [31:0] as [4];
    logic [31:0] bs [4];
    int cyc;
    as[0] = 32'd6;         bs[0] = 32'd7;
    as[1] = 32'hFFFF_FFFF; bs[1] = 32'd2;
    as[2] = $urandom;      bs[2] = $urandom;
    as[3] = $urandom;      bs[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      run_mul(as[i], bs[i], cyc);
      vectors++;
      if (cyc != 33) begin errors++; $display("FAIL mul_stall_len_%0d: got %0d want 33", i, cyc); end
    end
  endtask

  task automatic test_mul_reset;
    drive_op(4'b1110, $urandom, $urandom);
    repeat (10) tick;
    #1;
    vectors++;
    if (stall_exe !== 1'b1) begin errors++; $display("FAIL mul_pre_reset_stall: got %b want 1", stall_exe); end
    rst = 1'b1;
    drive_op(4'b0010, 32'd1, 32'd1);
    #1;
    vectors++;
    if (stall_exe !== 1'b0) begin errors++; $display("FAIL mul_reset_stall: got %b want 0", stall_exe); end
    tick;
    rst = 1'b0;
    model_mem = '0;
    #1;
    vectors++;
    if (stall_exe !== 1'b0 || regwrite_mem !== 1'b0 || aluout_mem !== 32'd0) begin
      errors++;
      $display("FAIL mul_abort: got stall=%b rw=%b alu=%h want 0 0 0", stall_exe, regwrite_mem, aluout_mem);
    end
    tick;
    vectors++;
    if (aluout_mem !== 32'd2 || regwrite_mem !== 1'b1) begin
      errors++;
      $display("FAIL add_after_abort: got alu=%h rw=%b want 00000002 1", aluout_mem, regwrite_mem);
    end
    model_mem = 32'd2;
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    run_mul(32'd3, 32'd4, c1);
    run_mul(32'd5, 32'd5, c2);
    vectors++;
    if (c1 + c2 != 66) begin errors++; $display("FAIL b2b_stall_total: got %0d want 66", c1 + c2); end
    drive_op(4'b1010, 32'd0, 32'h8000_0000);
    shamt_exe = 5'd4;
    tick;
    vectors++;
    if (aluout_mem !== 32'hF800_0000) begin
      errors++;
      $display("FAIL sra_after_mul: got %h want f8000000", aluout_mem);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_op(4'b0010, '0, '0);
    tick;
    test_reset;
    test_alu_directed;
    test_alu_random;
    test_forwarding;
    test_mul;
    test_mul_reset;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
